cpu_mpu_ctrl: RTL and testbench

Supervisor-side controller for the data MPU. Owns the eight region CSRs (`csr_dmpu0..7`) that drive the MPU checker and services CSR reads and writes to them. Captures access violations into a fault address/status register pair with a level interrupt and acknowledge handshake. Runs a multi-cycle clear-all sequence over the region table. Sits between the CPU CSR unit and the MPU checker, in the CPU clock domain.

---
 rtl/cpu_mpu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cpu_mpu_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mpu_ctrl.sv
// rtl/cpu_mpu_ctrl.sv - data MPU region CSRs, fault capture and clear-all sequencer (optional lock: CPU_MPU_LOCK_EN)
module cpu_mpu_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        supervisor,
    input  logic        csr_write,
    input  logic [3:0]  csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic        cpud_request,
    input  logic        cpud_write,
    input  logic [31:0] cpud_addr,
    input  logic        access_deny,
    input  logic        fault_ack,
    output logic        fault_irq,
    output logic        busy,
    output logic [31:0] csr_dmpu0,
    output logic [31:0] csr_dmpu1,
    output logic [31:0] csr_dmpu2,
    output logic [31:0] csr_dmpu3,
    output logic [31:0] csr_dmpu4,
    output logic [31:0] csr_dmpu5,
    output logic [31:0] csr_dmpu6,
    output logic [31:0] csr_dmpu7
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  clr_idx;
    logic [31:0] region [8];
    logic [7:0]  locked;
    logic [31:0] wdata_store;

    logic        req_q;
    logic        wr_q;
    logic [31:0] addr_q;

    logic [31:0] fault_addr;
    logic        f_valid;
    logic        f_write;
    logic        f_ovf;
    logic [7:0]  deny_cnt;

    logic        accept;
    logic        ctrl_wr;
    logic        start_clear;
    logic        zero_cnt;
    logic        qdeny;

    assign busy        = (state == CLEAR);
    assign accept      = csr_write & supervisor & ~busy;
    assign ctrl_wr     = accept && (csr_addr == 4'd10);
    assign start_clear = ctrl_wr & csr_wdata[0];
    assign zero_cnt    = ctrl_wr & csr_wdata[2];
    assign qdeny       = req_q & access_deny;
    assign fault_irq   = f_valid;

`ifdef CPU_MPU_LOCK_EN
    for (genvar g = 0; g < 8; g++) begin : g_lock
        assign locked[g] = region[g][11];
    end
    assign wdata_store = csr_wdata;
`else
    assign locked      = '0;
    assign wdata_store = csr_wdata & ~32'h0000_0800;
`endif

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_clear) state_next = CLEAR;
            CLEAR:   if (clr_idx == 3'd7) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset)           clr_idx <= '0;
        else if (start_clear) clr_idx <= '0;
        else if (busy)        clr_idx <= clr_idx + 3'd1;
    end

    // Clear and CSR writes never collide: writes are refused while busy.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 8; i++) begin
            if (!reset)
                region[i] <= '0;
            else if (busy && clr_idx == 3'(i) && !locked[i])
                region[i] <= '0;
            else if (accept && csr_addr == 4'(i) && !locked[i])
                region[i] <= wdata_store;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            req_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            req_q  <= cpud_request;
            wr_q   <= cpud_write;
            addr_q <= cpud_addr;
        end
    end

    // A deny coinciding with an ack is treated as a fresh first fault.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fault_addr <= '0;
            f_valid    <= 1'b0;
            f_write    <= 1'b0;
            f_ovf      <= 1'b0;
        end else if (qdeny) begin
            if (!f_valid || fault_ack) begin
                fault_addr <= addr_q;
                f_write    <= wr_q;
                f_valid    <= 1'b1;
                f_ovf      <= 1'b0;
            end else begin
                f_ovf      <= 1'b1;
            end
        end else if (fault_ack) begin
            f_valid <= 1'b0;
            f_ovf   <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)                          deny_cnt <= '0;
        else if (zero_cnt)                   deny_cnt <= '0;
        else if (qdeny && deny_cnt != 8'hFF) deny_cnt <= deny_cnt + 8'd1;
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            4'd0:    csr_rdata = region[0];
            4'd1:    csr_rdata = region[1];
            4'd2:    csr_rdata = region[2];
            4'd3:    csr_rdata = region[3];
            4'd4:    csr_rdata = region[4];
            4'd5:    csr_rdata = region[5];
            4'd6:    csr_rdata = region[6];
            4'd7:    csr_rdata = region[7];
            4'd8:    csr_rdata = fault_addr;
            4'd9:    csr_rdata = {16'h0000, deny_cnt, 5'b00000, f_ovf, f_write, f_valid};
            4'd10:   csr_rdata = {31'h0, busy};
            default: csr_rdata = '0;
        endcase
    end

    assign csr_dmpu0 = region[0];
    assign csr_dmpu1 = region[1];
    assign csr_dmpu2 = region[2];
    assign csr_dmpu3 = region[3];
    assign csr_dmpu4 = region[4];
    assign csr_dmpu5 = region[5];
    assign csr_dmpu6 = region[6];
    assign csr_dmpu7 = region[7];

endmodule

// File: tb/tb_cpu_mpu_ctrl.sv
// tb/tb_cpu_mpu_ctrl.sv - randomized self-checking bench for cpu_mpu_ctrl
module tb_cpu_mpu_ctrl;

`ifdef CPU_MPU_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        supervisor = 1'b0;
    logic        csr_write = 1'b0;
    logic [3:0]  csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        cpud_request = 1'b0;
    logic        cpud_write = 1'b0;
    logic [31:0] cpud_addr = '0;
    logic        access_deny = 1'b0;
    logic        fault_ack = 1'b0;
    logic        fault_irq;
    logic        busy;
    logic [31:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic [31:0] dmpu [8];

    assign dmpu[0] = d0;
    assign dmpu[1] = d1;
    assign dmpu[2] = d2;
    assign dmpu[3] = d3;
    assign dmpu[4] = d4;
    assign dmpu[5] = d5;
    assign dmpu[6] = d6;
    assign dmpu[7] = d7;

    cpu_mpu_ctrl dut (
        .clock(clock), .reset(reset), .supervisor(supervisor),
        .csr_write(csr_write), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .cpud_request(cpud_request), .cpud_write(cpud_write), .cpud_addr(cpud_addr),
        .access_deny(access_deny), .fault_ack(fault_ack), .fault_irq(fault_irq), .busy(busy),
        .csr_dmpu0(d0), .csr_dmpu1(d1), .csr_dmpu2(d2), .csr_dmpu3(d3),
        .csr_dmpu4(d4), .csr_dmpu5(d5), .csr_dmpu6(d6), .csr_dmpu7(d7)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: region table, fault record, and the cycle the last clear started.
    logic [31:0] m_reg [8];
    logic [31:0] m_faddr;
    logic        m_valid, m_wr, m_ovf;
    int          m_cnt;
    logic        m_req, m_wrq;
    logic [31:0] m_addrq;
    int          cyc = 0;
    int          clr_t = -100;

    function automatic logic m_busy();
        return (cyc >= clr_t + 1) && (cyc <= clr_t + 8);
    endfunction

    function automatic logic m_locked(int i);
        return LOCK_EN && m_reg[i][11];
    endfunction

    function automatic logic [31:0] m_read(logic [3:0] a);
        logic [7:0] c;
        c = m_cnt[7:0];
        if (a < 4'd8) return m_reg[a[2:0]];
        if (a == 4'd8) return m_faddr;
        if (a == 4'd9) return {16'h0, c, 5'b0, m_ovf, m_wr, m_valid};
        if (a == 4'd10) return {31'h0, m_busy()};
        return 32'h0;
    endfunction

    task automatic tick();
        logic busy_m, acc, qd;
        @(posedge clock);
        busy_m = m_busy();
        acc = csr_write && supervisor && !busy_m;
        qd = m_req && access_deny;
        if (!reset) begin
            for (int i = 0; i < 8; i++) m_reg[i] = '0;
            m_faddr = '0; m_valid = 0; m_wr = 0; m_ovf = 0; m_cnt = 0;
            m_req = 0; m_wrq = 0; m_addrq = '0; clr_t = -100;
        end else begin
            if (busy_m && !m_locked(cyc - clr_t - 1)) m_reg[cyc - clr_t - 1] = '0;
            if (acc && csr_addr < 4'd8 && !m_locked(int'(csr_addr)))
                m_reg[csr_addr[2:0]] = LOCK_EN ? csr_wdata : (csr_wdata & 32'hFFFF_F7FF);
            if (acc && csr_addr == 4'd10 && csr_wdata[0]) clr_t = cyc;
            if (acc && csr_addr == 4'd10 && csr_wdata[2]) m_cnt = 0;
            else if (qd && m_cnt < 255) m_cnt++;
            if (qd) begin
                if (!m_valid || fault_ack) begin
                    m_faddr = m_addrq; m_wr = m_wrq; m_valid = 1; m_ovf = 0;
                end else begin
                    m_ovf = 1;
                end
            end else if (fault_ack) begin
                m_valid = 0; m_ovf = 0;
            end
            m_req = cpud_request; m_wrq = cpud_write; m_addrq = cpud_addr;
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d, input logic sup);
        csr_write = 1; csr_addr = a; csr_wdata = d; supervisor = sup;
        tick();
        csr_write = 0; supervisor = 0;
    endtask

    task automatic do_access(input logic [31:0] a, input logic w, input logic ack);
        cpud_request = 1; cpud_addr = a; cpud_write = w;
        tick();
        cpud_request = 0; cpud_write = 0; access_deny = 1; fault_ack = ack;
        tick();
        access_deny = 0; fault_ack = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dmpu[i] !== 32'h0) begin errors++; $display("FAIL reset_dmpu%0d: got %h expected 0", i, dmpu[i]); end
        end
        checks++;
        if (fault_irq !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_flags: irq=%b busy=%b expected 0 0", fault_irq, busy);
        end
        for (int a = 8; a <= 10; a++) begin
            csr_addr = 4'(a); #1;
            checks++;
            if (csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_csr%0d: got %h expected 0", a, csr_rdata); end
        end
        reset = 1;
    endtask

    task automatic test_region_write();
        csr_wr(4'd2, 32'h8000_0304, 1);
        checks++;
        if (d2 !== 32'h8000_0304) begin errors++; $display("FAIL sup_write: got %h expected 80000304", d2); end
        csr_addr = 4'd2; #1;
        checks++;
        if (csr_rdata !== 32'h8000_0304) begin errors++; $display("FAIL sup_read: got %h expected 80000304", csr_rdata); end
        csr_wr(4'd2, 32'h1111_2222, 0);
        checks++;
        if (d2 !== 32'h8000_0304) begin errors++; $display("FAIL user_write_dropped: got %h expected 80000304", d2); end
    endtask

    task automatic test_fault();
        do_access(32'h1234_5678, 0, 0);
        csr_addr = 4'd8; #1;
        checks++;
        if (csr_rdata !== 32'h1234_5678) begin errors++; $display("FAIL fault_addr: got %h expected 12345678", csr_rdata); end
        csr_addr = 4'd9; #1;
        checks++;
        if (csr_rdata !== 32'h0000_0101 || fault_irq !== 1'b1) begin
            errors++; $display("FAIL fault_status: got %h irq %b expected 00000101 irq 1", csr_rdata, fault_irq);
        end
        do_access(32'h1111_0000, 1, 0);
        csr_addr = 4'd8; #1;
        checks++;
        if (csr_rdata !== 32'h1234_5678) begin errors++; $display("FAIL overflow_addr: got %h expected 12345678", csr_rdata); end
        csr_addr = 4'd9; #1;
        checks++;
        if (csr_rdata !== 32'h0000_0205) begin errors++; $display("FAIL overflow_status: got %h expected 00000205", csr_rdata); end
        fault_ack = 1;
        tick();
        fault_ack = 0;
        #1;
        checks++;
        if (csr_rdata !== 32'h0000_0200 || fault_irq !== 1'b0) begin
            errors++; $display("FAIL ack_status: got %h irq %b expected 00000200 irq 0", csr_rdata, fault_irq);
        end
        do_access(32'h5555_0000, 0, 0);
        do_access(32'hA000_0000, 1, 1);
        csr_addr = 4'd8; #1;
        checks++;
        if (csr_rdata !== 32'hA000_0000) begin errors++; $display("FAIL ack_deny_addr: got %h expected a0000000", csr_rdata); end
        csr_addr = 4'd9; #1;
        checks++;
        if (csr_rdata !== 32'h0000_0403 || fault_irq !== 1'b1) begin
            errors++; $display("FAIL ack_deny_status: got %h irq %b expected 00000403 irq 1", csr_rdata, fault_irq);
        end
        fault_ack = 1;
        tick();
        fault_ack = 0;
    endtask

    task automatic test_saturate();
        csr_wr(4'd10, 32'h4, 1);
        cpud_request = 1; cpud_addr = 32'h0000_1000;
        tick();
        access_deny = 1;
        for (int k = 0; k < 255; k++) tick();
        cpud_request = 0;
        tick();
        access_deny = 0;
        csr_addr = 4'd9; #1;
        checks++;
        if (csr_rdata !== 32'h0000_FF05) begin errors++; $display("FAIL saturate: got %h expected 0000ff05", csr_rdata); end
        fault_ack = 1;
        tick();
        fault_ack = 0;
        csr_wr(4'd10, 32'h4, 1);
        csr_addr = 4'd9; #1;
        checks++;
        if (csr_rdata !== 32'h0) begin errors++; $display("FAIL count_zero: got %h expected 0", csr_rdata); end
    endtask

    task automatic test_clear();
        int nb;
        csr_wr(4'd5, 32'h0000_0800, 1);
        checks++;
        if (d5 !== (LOCK_EN ? 32'h0000_0800 : 32'h0)) begin
            errors++; $display("FAIL lock_store: got %h expected %h", d5, LOCK_EN ? 32'h800 : 32'h0);
        end
        for (int i = 0; i < 8; i++)
            if (i != 5) csr_wr(4'(i), ($urandom() & 32'hFFFF_F7FF) | 32'h1, 1);
        csr_wr(4'd10, 32'h1, 1);
        nb = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            csr_write = (k == 7); supervisor = 1; csr_addr = 4'd0; csr_wdata = 32'hDEAD_0000;
            tick();
            nb++;
        end
        csr_write = 0; supervisor = 0;
        checks++;
        if (nb !== 8) begin errors++; $display("FAIL busy_len: got %0d expected 8", nb); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dmpu[i] !== ((i == 5 && LOCK_EN) ? 32'h0000_0800 : 32'h0)) begin
                errors++; $display("FAIL clear_region%0d: got %h", i, dmpu[i]);
            end
        end
        csr_wr(4'd5, 32'h1234_0000, 1);
        checks++;
        if (d5 !== (LOCK_EN ? 32'h0000_0800 : 32'h1234_0000)) begin
            errors++; $display("FAIL locked_write: got %h expected %h", d5, LOCK_EN ? 32'h800 : 32'h12340000);
        end
    endtask

    task automatic test_reset_mid_clear();
        csr_wr(4'd3, 32'h0000_0800, 1);
        csr_wr(4'd6, 32'h0000_0F05, 1);
        csr_wr(4'd10, 32'h1, 1);
        tick();
        reset = 0;
        tick();
        reset = 1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dmpu[i] !== 32'h0) begin errors++; $display("FAIL midclear_region%0d: got %h expected 0", i, dmpu[i]); end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midclear_busy: got %b expected 0", busy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            supervisor = ($urandom_range(0, 3) != 0);
            csr_write = ($urandom_range(0, 3) == 0);
            csr_addr = 4'($urandom_range(0, 15));
            csr_wdata = $urandom();
            if ($urandom_range(0, 7) != 0) csr_wdata[11] = 1'b0;
            cpud_request = 1'($urandom_range(0, 1));
            cpud_write = 1'($urandom_range(0, 1));
            cpud_addr = $urandom();
            access_deny = 1'($urandom_range(0, 1));
            fault_ack = ($urandom_range(0, 5) == 0);
            #1;
            checks++;
            if (csr_rdata !== m_read(csr_addr)) begin
                errors++; $display("FAIL rand_rdata[%0d] addr %0d: got %h expected %h", n, csr_addr, csr_rdata, m_read(csr_addr));
            end
            checks++;
            if (fault_irq !== m_valid || busy !== m_busy()) begin
                errors++; $display("FAIL rand_flags[%0d]: irq %b busy %b expected %b %b", n, fault_irq, busy, m_valid, m_busy());
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (dmpu[i] !== m_reg[i]) begin
                    errors++; $display("FAIL rand_dmpu%0d[%0d]: got %h expected %h", i, n, dmpu[i], m_reg[i]);
                end
            end
            tick();
        end
        csr_write = 0; cpud_request = 0; access_deny = 0; fault_ack = 0;
    endtask

    initial begin
        test_reset();
        test_region_write();
        test_fault();
        test_saturate();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
